pc_sequencer: RTL and testbench

//  Next-PC controller for the single-issue MIPS core: owns the PC register and picks

---
 rtl/pc_sequencer.sv | 174 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
//   Next-PC controller for the single-issue MIPS core. Owns the PC register and
//   each cycle selects the sequential, branch, jump (J/JAL) or register (JR)
//   target. Every taken redirect is followed by one bubble cycle that squashes
//   the slot fetched from the new target.
//
//   Optional feature macro: MISALIGN_TRAP_EN
//     defined   : JR to a non word-aligned address loads TRAP_VECTOR instead and
//                 pulses misalign_trap for that cycle.
//     undefined : the low two bits of the JR target are forced to 00 and
//                 misalign_trap is tied low.
//
// Ports
//   clk             rising-edge clock
//   reset           synchronous, active-high reset
//   stall           hold pc (hazard unit)
//   jump            J/JAL decoded
//   jump_reg        JR decoded
//   branch          BEQ/BNE decoded
//   branch_ne       1 = BNE, 0 = BEQ
//   alu_zero        ALU zero flag for the branch compare
//   instr_index     J-type target field
//   branch_offset   I-type immediate (signed word offset)
//   reg_target      rs value for JR
//   pc              current fetch address
//   pc_plus4        pc + 4 (combinational)
//   fetch_valid     instruction at pc is to be executed
//   flush           one-cycle pulse squashing the slot after a redirect
//   misalign_trap   one-cycle pulse on a misaligned JR
//   redirect_count  taken redirects since reset, saturating
// ----------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             jump,
    input  logic             jump_reg,
    input  logic             branch,
    input  logic             branch_ne,
    input  logic             alu_zero,
    input  logic [25:0]      instr_index,
    input  logic [15:0]      branch_offset,
    input  logic [31:0]      reg_target,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             fetch_valid,
    output logic             flush,
    output logic             misalign_trap,
    output logic [CNT_W-1:0] redirect_count
);

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HOLD   = 2'd2,
        ST_BUBBLE = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] target;
    logic        branch_taken;
    logic        redirect;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values computed before the edge, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        pc_plus4      = pc_q + 32'd4;
        branch_taken  = branch & (alu_zero ^ branch_ne);
        branch_target = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
        jump_target   = {pc_plus4[31:28], instr_index, 2'b00};

        state_d       = state_q;
        pc_d          = pc_q;
        cnt_d         = cnt_q;
        target        = pc_plus4;
        redirect      = 1'b0;
        fetch_valid   = 1'b0;
        flush         = 1'b0;
        misalign_trap = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end

            ST_RUN: begin
                fetch_valid = 1'b1;
                // A stall outranks any control transfer; it is re-evaluated
                // against the same pc once the stall releases.
                if (stall) begin
                    state_d = ST_HOLD;
                end else if (jump_reg) begin
                    redirect = 1'b1;
                    if (TRAP_EN && (reg_target[1:0] != 2'b00)) begin
                        target        = TRAP_VECTOR;
                        misalign_trap = 1'b1;
                    end else begin
                        target = {reg_target[31:2], 2'b00};
                    end
                end else if (jump) begin
                    redirect = 1'b1;
                    target   = jump_target;
                end else if (branch_taken) begin
                    redirect = 1'b1;
                    target   = branch_target;
                end else begin
                    pc_d = pc_plus4;
                end

                // A target equal to the current pc still counts as a redirect.
                if (redirect) begin
                    pc_d    = target;
                    state_d = ST_BUBBLE;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_HOLD: begin
                fetch_valid = 1'b1;
                if (!stall) begin
                    state_d = ST_RUN;
                end
            end

            ST_BUBBLE: begin
                // The slot at the new target is squashed; execution resumes at
                // target + 4. Stall and decode controls are ignored here.
                flush   = 1'b1;
                pc_d    = pc_plus4;
                state_d = ST_RUN;
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    assign pc             = pc_q;
    assign redirect_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_sequencer
//   Directed, self-checking bench for pc_sequencer. The counter is built narrow
//   (4 bits) so saturation is reachable in a short run. Inputs change 1 ns after
//   the rising edge; outputs are compared at that point, well before the next
//   edge.
// ----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam int          CW      = 4;
    localparam int          CNT_MAX = (1 << CW) - 1;
`ifdef MISALIGN_TRAP_EN
    localparam logic [31:0] EXP_JR_PC = 32'h0000_0080;
    localparam logic        EXP_TRAP  = 1'b1;
`else
    localparam logic [31:0] EXP_JR_PC = 32'h0000_0200;
    localparam logic        EXP_TRAP  = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          stall;
    logic          jump;
    logic          jump_reg;
    logic          branch;
    logic          branch_ne;
    logic          alu_zero;
    logic [25:0]   instr_index;
    logic [15:0]   branch_offset;
    logic [31:0]   reg_target;
    logic [31:0]   pc;
    logic [31:0]   pc_plus4;
    logic          fetch_valid;
    logic          flush;
    logic          misalign_trap;
    logic [CW-1:0] redirect_count;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_cnt  = 0;

    pc_sequencer #(
        .RESET_PC   (32'h0000_0000),
        .TRAP_VECTOR(32'h0000_0080),
        .CNT_W      (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .jump          (jump),
        .jump_reg      (jump_reg),
        .branch        (branch),
        .branch_ne     (branch_ne),
        .alu_zero      (alu_zero),
        .instr_index   (instr_index),
        .branch_offset (branch_offset),
        .reg_target    (reg_target),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .fetch_valid   (fetch_valid),
        .flush         (flush),
        .misalign_trap (misalign_trap),
        .redirect_count(redirect_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        stall         = 1'b0;
        jump          = 1'b0;
        jump_reg      = 1'b0;
        branch        = 1'b0;
        branch_ne     = 1'b0;
        alu_zero      = 1'b0;
        instr_index   = '0;
        branch_offset = '0;
        reg_target    = '0;
    endtask

    task automatic bump();
        if (exp_cnt < CNT_MAX) exp_cnt++;
    endtask

    // From a RUN cycle, JR to p-4 so that the following RUN cycle sits at p.
    task automatic goto_pc(input logic [31:0] p);
        jump_reg   = 1'b1;
        reg_target = p - 32'd4;
        step();
        clear_ctrl();
        step();
        bump();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_ctrl();
        step();
        step();
        n_checks++;
        if ({pc, fetch_valid, flush, misalign_trap, redirect_count} !== {32'h0, 1'b0, 1'b0, 1'b0, 4'h0})
            $display("FAIL reset: got pc=%h fv=%b fl=%b trap=%b cnt=%0d, want pc=0 fv=0 fl=0 trap=0 cnt=0",
                     pc, fetch_valid, flush, misalign_trap, redirect_count);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        step();
        n_checks++;
        if ({pc, fetch_valid} !== {32'h0, 1'b1})
            $display("FAIL boot_exit: got pc=%h fv=%b, want pc=0 fv=1", pc, fetch_valid);
        else n_pass++;
        for (int i = 1; i <= 3; i++) begin
            step();
            exp_pc = 32'(i * 4);
            n_checks++;
            if ({pc, fetch_valid, flush} !== {exp_pc, 1'b1, 1'b0})
                $display("FAIL seq_%0d: got pc=%h fv=%b fl=%b, want pc=%h fv=1 fl=0",
                         i, pc, fetch_valid, flush, exp_pc);
            else n_pass++;
        end
        n_checks++;
        if ({pc_plus4, redirect_count} !== {32'h0000_0010, 4'h0})
            $display("FAIL seq_plus4: got pc_plus4=%h cnt=%0d, want 00000010 cnt=0", pc_plus4, redirect_count);
        else n_pass++;
    endtask

    task automatic test_jump();
        goto_pc(32'h1000_0010);
        jump        = 1'b1;
        instr_index = 26'h000_0040;
        step();
        bump();
        n_checks++;
        if ({pc, fetch_valid, flush, redirect_count} !== {32'h1000_0100, 1'b0, 1'b1, 4'(exp_cnt)})
            $display("FAIL jump_target: got pc=%h fv=%b fl=%b cnt=%0d, want pc=10000100 fv=0 fl=1 cnt=%0d",
                     pc, fetch_valid, flush, redirect_count, exp_cnt);
        else n_pass++;
        clear_ctrl();
        step();
        n_checks++;
        if ({pc, fetch_valid, flush, redirect_count} !== {32'h1000_0104, 1'b1, 1'b0, 4'(exp_cnt)})
            $display("FAIL jump_resume: got pc=%h fv=%b fl=%b cnt=%0d, want pc=10000104 fv=1 fl=0 cnt=%0d",
                     pc, fetch_valid, flush, redirect_count, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_branch();
        goto_pc(32'h0000_0020);
        // BEQ taken, backwards offset of -2 words: 0x24 - 8 = 0x1C.
        branch        = 1'b1;
        alu_zero      = 1'b1;
        branch_offset = 16'hFFFE;
        step();
        bump();
        n_checks++;
        if ({pc, flush} !== {32'h0000_001C, 1'b1})
            $display("FAIL beq_taken: got pc=%h fl=%b, want pc=0000001c fl=1", pc, flush);
        else n_pass++;
        clear_ctrl();
        step();
        // BNE with alu_zero=1 is not taken.
        branch    = 1'b1;
        branch_ne = 1'b1;
        alu_zero  = 1'b1;
        step();
        n_checks++;
        if ({pc, fetch_valid, flush, redirect_count} !== {32'h0000_0024, 1'b1, 1'b0, 4'(exp_cnt)})
            $display("FAIL bne_not_taken: got pc=%h fv=%b fl=%b cnt=%0d, want pc=00000024 fv=1 fl=0 cnt=%0d",
                     pc, fetch_valid, flush, redirect_count, exp_cnt);
        else n_pass++;
        // BNE with alu_zero=0 is taken, forward 3 words: 0x28 + 12 = 0x34.
        alu_zero      = 1'b0;
        branch_offset = 16'h0003;
        step();
        bump();
        n_checks++;
        if ({pc, flush, redirect_count} !== {32'h0000_0034, 1'b1, 4'(exp_cnt)})
            $display("FAIL bne_taken: got pc=%h fl=%b cnt=%0d, want pc=00000034 fl=1 cnt=%0d",
                     pc, flush, redirect_count, exp_cnt);
        else n_pass++;
        clear_ctrl();
        step();
    endtask

    task automatic test_priority();
        // At pc 0x38: JR, J and a taken branch all asserted; JR must win.
        jump_reg      = 1'b1;
        reg_target    = 32'h0000_0300;
        jump          = 1'b1;
        instr_index   = 26'h000_0010;
        branch        = 1'b1;
        alu_zero      = 1'b1;
        branch_offset = 16'h0010;
        step();
        bump();
        n_checks++;
        if (pc !== 32'h0000_0300)
            $display("FAIL prio_jr: got pc=%h, want pc=00000300", pc);
        else n_pass++;
        clear_ctrl();
        step();
        // At pc 0x304: J (-> 0x40) beats a taken branch (-> 0x308 + 0x40).
        jump          = 1'b1;
        instr_index   = 26'h000_0010;
        branch        = 1'b1;
        alu_zero      = 1'b1;
        branch_offset = 16'h0010;
        step();
        bump();
        n_checks++;
        if (pc !== 32'h0000_0040)
            $display("FAIL prio_j: got pc=%h, want pc=00000040", pc);
        else n_pass++;
        clear_ctrl();
        step();
    endtask

    task automatic test_stall();
        goto_pc(32'h0000_0040);
        stall       = 1'b1;
        jump        = 1'b1;
        instr_index = 26'h000_0100;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({pc, fetch_valid, flush, redirect_count} !== {32'h0000_0040, 1'b1, 1'b0, 4'(exp_cnt)})
                $display("FAIL stall_hold_%0d: got pc=%h fv=%b fl=%b cnt=%0d, want pc=00000040 fv=1 fl=0 cnt=%0d",
                         i, pc, fetch_valid, flush, redirect_count, exp_cnt);
            else n_pass++;
        end
        stall = 1'b0;
        step();
        n_checks++;
        if ({pc, fetch_valid, flush} !== {32'h0000_0040, 1'b1, 1'b0})
            $display("FAIL stall_release: got pc=%h fv=%b fl=%b, want pc=00000040 fv=1 fl=0",
                     pc, fetch_valid, flush);
        else n_pass++;
        step();
        bump();
        n_checks++;
        if ({pc, flush, redirect_count} !== {32'h0000_0400, 1'b1, 4'(exp_cnt)})
            $display("FAIL stall_then_jump: got pc=%h fl=%b cnt=%0d, want pc=00000400 fl=1 cnt=%0d",
                     pc, flush, redirect_count, exp_cnt);
        else n_pass++;
        clear_ctrl();
        step();
    endtask

    task automatic test_jr_misalign();
        jump_reg   = 1'b1;
        reg_target = 32'h0000_0203;
        #1;
        n_checks++;
        if (misalign_trap !== EXP_TRAP)
            $display("FAIL jr_trap_pulse: got trap=%b, want trap=%b", misalign_trap, EXP_TRAP);
        else n_pass++;
        step();
        bump();
        n_checks++;
        if ({pc, flush, misalign_trap, redirect_count} !== {EXP_JR_PC, 1'b1, 1'b0, 4'(exp_cnt)})
            $display("FAIL jr_misalign: got pc=%h fl=%b trap=%b cnt=%0d, want pc=%h fl=1 trap=0 cnt=%0d",
                     pc, flush, misalign_trap, redirect_count, EXP_JR_PC, exp_cnt);
        else n_pass++;
        clear_ctrl();
        step();
    endtask

    task automatic test_same_target();
        logic [31:0] cur;
        cur        = EXP_JR_PC + 32'd4;
        jump_reg   = 1'b1;
        reg_target = cur;
        step();
        bump();
        n_checks++;
        if ({pc, flush, redirect_count} !== {cur, 1'b1, 4'(exp_cnt)})
            $display("FAIL same_target: got pc=%h fl=%b cnt=%0d, want pc=%h fl=1 cnt=%0d",
                     pc, flush, redirect_count, cur, exp_cnt);
        else n_pass++;
        // In BUBBLE: stall and every control asserted, all must be ignored.
        stall       = 1'b1;
        jump        = 1'b1;
        instr_index = 26'h3FF_FFFF;
        reg_target  = 32'h0000_0500;
        step();
        n_checks++;
        if ({pc, fetch_valid, flush, redirect_count} !== {cur + 32'd4, 1'b1, 1'b0, 4'(exp_cnt)})
            $display("FAIL bubble_ignores_ctrl: got pc=%h fv=%b fl=%b cnt=%0d, want pc=%h fv=1 fl=0 cnt=%0d",
                     pc, fetch_valid, flush, redirect_count, cur + 32'd4, exp_cnt);
        else n_pass++;
        clear_ctrl();
    endtask

    task automatic test_wrap();
        goto_pc(32'hFFFF_FFFC);
        n_checks++;
        if ({pc, pc_plus4} !== {32'hFFFF_FFFC, 32'h0})
            $display("FAIL wrap_plus4: got pc=%h pc_plus4=%h, want pc=fffffffc pc_plus4=00000000", pc, pc_plus4);
        else n_pass++;
        step();
        n_checks++;
        if ({pc, fetch_valid, flush} !== {32'h0, 1'b1, 1'b0})
            $display("FAIL wrap: got pc=%h fv=%b fl=%b, want pc=00000000 fv=1 fl=0", pc, fetch_valid, flush);
        else n_pass++;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            jump_reg   = 1'b1;
            reg_target = 32'h0000_0100;
            step();
            bump();
            clear_ctrl();
            step();
            n_checks++;
            if ({pc, redirect_count} !== {32'h0000_0104, 4'(exp_cnt)})
                $display("FAIL sat_%0d: got pc=%h cnt=%0d, want pc=00000104 cnt=%0d",
                         i, pc, redirect_count, exp_cnt);
            else n_pass++;
        end
    endtask

    task automatic test_reset_in_bubble();
        jump_reg   = 1'b1;
        reg_target = 32'h0000_0600;
        step();
        n_checks++;
        if ({pc, flush} !== {32'h0000_0600, 1'b1})
            $display("FAIL pre_reset_bubble: got pc=%h fl=%b, want pc=00000600 fl=1", pc, flush);
        else n_pass++;
        clear_ctrl();
        reset = 1'b1;
        step();
        exp_cnt = 0;
        n_checks++;
        if ({pc, fetch_valid, flush, redirect_count} !== {32'h0, 1'b0, 1'b0, 4'(exp_cnt)})
            $display("FAIL reset_in_bubble: got pc=%h fv=%b fl=%b cnt=%0d, want pc=0 fv=0 fl=0 cnt=0",
                     pc, fetch_valid, flush, redirect_count);
        else n_pass++;
        reset = 1'b0;
        step();
        step();
        n_checks++;
        if ({pc, fetch_valid} !== {32'h0000_0004, 1'b1})
            $display("FAIL post_reset_run: got pc=%h fv=%b, want pc=00000004 fv=1", pc, fetch_valid);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jump();
        test_branch();
        test_priority();
        test_stall();
        test_jr_misalign();
        test_same_target();
        test_wrap();
        test_saturation();
        test_reset_in_bubble();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
